uart_rx_fifo: RTL and testbench

- Parametrised successor to the existing 16550-style serial receiver.
- Adds configurable oversampling, 3-sample majority voting, parity checking (odd/even/stick), break detection, and a receive FIFO with per-entry error flags and overrun.
- Sits between the baud generator's oversample tick and the register file's RBR/LSR logic.

---
 rtl/uart_rx_fifo.sv | 253 +++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampled serial receiver with majority vote, parity/break detection and flagged receive FIFO
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   tick              oversample enable, OVERSAMPLE pulses per bit period
//   srx               asynchronous serial input, idle high
//   lcr               [1:0] word length 5..8, [3] parity enable, [4] even parity, [5] stick parity
//   rd_en             pop head entry
//   lsr_rd            clears overrun_err
//   fifo_clr          flush FIFO and error-entry count
//   trig_level        fifo_count threshold for rx_trig (0 disables)
//   rbr_dout          head data byte (show-ahead, zero when empty)
//   head_pe/fe/bi     head entry parity error, framing error, break indication
//   data_ready        FIFO not empty
//   fifo_count        occupied entries
//   rx_trig           fifo_count >= trig_level with trig_level != 0
//   overrun_err       sticky overrun flag
//   err_in_fifo       at least one stored entry carries an error flag
module uart_rx_fifo #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 16,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          srx,
  input  logic [7:0]    lcr,
  input  logic          rd_en,
  input  logic          lsr_rd,
  input  logic          fifo_clr,
  input  logic [CW-1:0] trig_level,
  output logic [7:0]    rbr_dout,
  output logic          head_pe,
  output logic          head_fe,
  output logic          head_bi,
  output logic          data_ready,
  output logic [CW-1:0] fifo_count,
  output logic          rx_trig,
  output logic          overrun_err,
  output logic          err_in_fifo
);

  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int M   = OVERSAMPLE / 2;
  localparam logic [OSW-1:0] OS_S0   = OSW'(M - 1);
  localparam logic [OSW-1:0] OS_S1   = OSW'(M);
  localparam logic [OSW-1:0] OS_S2   = OSW'(M + 1);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT
  } state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rxs_prev;
  logic [OSW-1:0]         r_os;
  logic                   r_samp0, r_samp1;
  logic [7:0]             r_shift;
  logic [2:0]             r_bit_idx;
  logic [1:0]             r_wls;
  logic                   r_pen, r_eps, r_stick;
  logic                   r_par_samp, r_pe;

  logic       w_rxs, w_fall, w_resolve, w_bit_end, w_vote, w_last_bit;
  logic       w_par_exp, w_fe, w_bi, w_push;
  logic [10:0] w_entry;
  logic       w_unused;

  assign w_unused = ^{lcr[7:6], lcr[2]};

  // Synchroniser; all line sampling uses the last stage.
  assign w_rxs = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], srx};
    end
  end

  assign w_fall     = r_rxs_prev & ~w_rxs;
  assign w_resolve  = tick && (r_os == OS_S2);
  assign w_bit_end  = tick && (r_os == OS_LAST);
  // Third vote sample is the live line value on the resolve tick.
  assign w_vote     = (r_samp0 & r_samp1) | (r_samp0 & w_rxs) | (r_samp1 & w_rxs);
  assign w_last_bit = (r_bit_idx == ({1'b0, r_wls} + 3'd4));
  // Unused upper shift bits are zero, so the full-width reduction is the data parity.
  assign w_par_exp  = r_stick ? ~r_eps : ((^r_shift) ^ ~r_eps);
  assign w_fe       = ~w_vote;
  assign w_bi       = w_fe & (r_shift == 8'h00) & (~r_pen | ~r_par_samp);
  assign w_entry    = {w_bi, w_fe, r_pe, r_shift};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) w_state_nxt = S_START;
      end
      S_START: begin
        if (w_resolve && w_vote) w_state_nxt = S_IDLE;
        else if (w_bit_end)      w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end && w_last_bit) w_state_nxt = r_pen ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (w_bit_end) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        // Leave mid stop bit so the next start edge is caught early.
        if (w_resolve) begin
          w_push      = 1'b1;
          w_state_nxt = w_bi ? S_BRK_WAIT : S_IDLE;
        end
      end
      S_BRK_WAIT: begin
        if (w_rxs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxs_prev <= 1'b1;
      r_os       <= '0;
      r_samp0    <= 1'b1;
      r_samp1    <= 1'b1;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_wls      <= '0;
      r_pen      <= 1'b0;
      r_eps      <= 1'b0;
      r_stick    <= 1'b0;
      r_par_samp <= 1'b0;
      r_pe       <= 1'b0;
    end else begin
      r_rxs_prev <= w_rxs;
      if (r_state == S_IDLE || r_state == S_BRK_WAIT) begin
        r_os <= '0;
      end else if (tick) begin
        r_os <= (r_os == OS_LAST) ? '0 : r_os + 1'b1;
      end
      if (tick && r_os == OS_S0) r_samp0 <= w_rxs;
      if (tick && r_os == OS_S1) r_samp1 <= w_rxs;
      case (r_state)
        S_START: begin
          // Frame format is frozen once the start bit is confirmed.
          if (w_resolve && !w_vote) begin
            r_wls      <= lcr[1:0];
            r_pen      <= lcr[3];
            r_eps      <= lcr[4];
            r_stick    <= lcr[5];
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_par_samp <= 1'b0;
            r_pe       <= 1'b0;
          end
        end
        S_DATA: begin
          if (w_resolve) r_shift[r_bit_idx] <= w_vote;
          if (w_bit_end) r_bit_idx <= r_bit_idx + 1'b1;
        end
        S_PARITY: begin
          if (w_resolve) begin
            r_par_samp <= w_vote;
            r_pe       <= (w_vote != w_par_exp);
          end
        end
        default: ;
      endcase
    end
  end

  logic [10:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count, r_err_cnt;
  logic          r_overrun;

  logic        w_empty, w_full, w_pop, w_wr, w_ovr, w_entry_err, w_head_err;
  logic [10:0] w_head;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_head      = r_mem[r_rptr];
  assign w_pop       = rd_en & ~w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_wr        = w_push & (~w_full | w_pop) & ~fifo_clr;
  assign w_ovr       = w_push & w_full & ~w_pop & ~fifo_clr;
  assign w_entry_err = |w_entry[10:8];
  assign w_head_err  = |w_head[10:8];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= w_entry;
  end

  always_ff @(posedge clk) begin
    if (rst || fifo_clr) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
      case ({w_wr & w_entry_err, w_pop & w_head_err})
        2'b10:   r_err_cnt <= r_err_cnt + 1'b1;
        2'b01:   r_err_cnt <= r_err_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_ovr) begin
      r_overrun <= 1'b1;
    end else if (lsr_rd) begin
      r_overrun <= 1'b0;
    end
  end

  assign data_ready  = ~w_empty;
  assign rbr_dout    = data_ready ? w_head[7:0] : 8'h00;
  assign head_pe     = data_ready & w_head[8];
  assign head_fe     = data_ready & w_head[9];
  assign head_bi     = data_ready & w_head[10];
  assign fifo_count  = r_count;
  assign rx_trig     = (trig_level != '0) && (r_count >= trig_level);
  assign overrun_err = r_overrun;
  assign err_in_fifo = (r_err_cnt != '0);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a frame-level queue model
module tb_uart_rx_fifo;

  localparam int OS    = 16;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int NPOS  = OS / 2 + 1;
  localparam int PPOS  = OS / 2 + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick = 1'b0;
  logic          srx;
  logic [7:0]    lcr;
  logic          rd_en, lsr_rd, fifo_clr;
  logic [CW-1:0] trig_level;
  logic [7:0]    rbr_dout;
  logic          head_pe, head_fe, head_bi, data_ready;
  logic [CW-1:0] fifo_count;
  logic          rx_trig, overrun_err, err_in_fifo;

  int errors = 0;
  int checks = 0;

  logic [10:0] mq[$];
  bit          m_ovr = 1'b0;

  uart_rx_fifo #(.OVERSAMPLE(OS), .SYNC_STAGES(2), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .tick(tick), .srx(srx), .lcr(lcr),
    .rd_en(rd_en), .lsr_rd(lsr_rd), .fifo_clr(fifo_clr), .trig_level(trig_level),
    .rbr_dout(rbr_dout), .head_pe(head_pe), .head_fe(head_fe), .head_bi(head_bi),
    .data_ready(data_ready), .fifo_count(fifo_count), .rx_trig(rx_trig),
    .overrun_err(overrun_err), .err_in_fifo(err_in_fifo)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1 tick = ~tick;
    end
  end

  function automatic bit par_bit(input logic [7:0] data, input logic [7:0] cfg);
    int wl, ones;
    wl = 5 + int'(cfg[1:0]);
    ones = 0;
    for (int i = 0; i < wl; i++) ones += int'(data[i]);
    if (cfg[5]) return !cfg[4];
    if (cfg[4]) return (ones % 2) == 1;
    return (ones % 2) == 0;
  endfunction

  function automatic logic [10:0] exp_entry(input logic [7:0] data, input logic [7:0] cfg,
                                            input bit bad_par, input bit stop_val);
    int wl;
    logic [7:0] d;
    bit pen, pb, fe, bi, pe;
    wl = 5 + int'(cfg[1:0]);
    d = 8'h00;
    for (int i = 0; i < wl; i++) d[i] = data[i];
    pen = cfg[3];
    pb = par_bit(data, cfg) ^ bad_par;
    fe = !stop_val;
    bi = fe && (d == 8'h00) && (!pen || !pb);
    pe = pen && bad_par;
    return {bi, fe, pe, (bi ? 8'h00 : d)};
  endfunction

  function automatic void model_push(input logic [10:0] e);
    if (mq.size() < DEPTH) mq.push_back(e);
    else m_ovr = 1'b1;
  endfunction

  function automatic bit model_err();
    foreach (mq[i]) if (mq[i][10:8] != 3'b000) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_trig();
    return (trig_level != '0) && (mq.size() >= int'(trig_level));
  endfunction

  task automatic wait_tick();
    do begin
      @(posedge clk);
      #2;
    end while (!tick);
  endtask

  task automatic hold_line(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      srx = v;
      wait_tick();
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic [7:0] cfg, input bit bad_par,
                            input bit stop_val, input logic [7:0] noise, input bit pop_at_push);
    int wl, nb;
    bit pen, pb;
    logic v;
    wl = 5 + int'(cfg[1:0]);
    pen = cfg[3];
    pb = par_bit(data, cfg) ^ bad_par;
    nb = 2 + wl + (pen ? 1 : 0);
    lcr = cfg;
    wait_tick();
    for (int b = 0; b < nb; b++) begin
      if (b == 0) v = 1'b0;
      else if (b <= wl) v = data[b-1];
      else if (pen && b == wl + 1) v = pb;
      else v = stop_val;
      for (int p = 0; p < OS; p++) begin
        srx = (p == NPOS && b >= 1 && b <= wl && noise[b-1]) ? ~v : v;
        if (b == 3 && p == 0) lcr = 8'($urandom);
        if (pop_at_push && b == nb - 1 && p == PPOS) begin
          rd_en = 1'b1;
          @(posedge clk);
          #2;
          rd_en = 1'b0;
          while (!tick) begin
            @(posedge clk);
            #2;
          end
        end else begin
          wait_tick();
        end
      end
    end
    hold_line(1'b1, 2);
    if (pop_at_push) void'(mq.pop_front());
    model_push(exp_entry(data, cfg, bad_par, stop_val));
  endtask

  task automatic read_head(output logic [10:0] h);
    h = {head_bi, head_fe, head_pe, rbr_dout};
    rd_en = 1'b1;
    @(posedge clk);
    #2;
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [24:0] outs;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    outs = {rbr_dout, head_pe, head_fe, head_bi, data_ready, fifo_count, rx_trig, overrun_err, err_in_fifo};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    rst = 1'b0;
    lcr = 8'h03;
    wait_tick();
    hold_line(1'b0, OS);
    hold_line(1'b1, 40);
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    hold_line(1'b1, 250);
    checks++;
    if (fifo_count !== '0 || data_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_midframe: got count %0d ready %b expected 0 0", fifo_count, data_ready);
    end
  endtask

  task automatic test_basic_8n1();
    logic [10:0] h, e;
    send_frame(8'hA5, 8'h03, 1'b0, 1'b1, 8'h00, 1'b0);
    send_frame(8'h3C, 8'h03, 1'b0, 1'b1, 8'h00, 1'b0);
    checks++;
    if (fifo_count !== CW'(2)) begin
      errors++;
      $display("FAIL basic_count: got %0d expected 2", fifo_count);
    end
    for (int i = 0; i < 2; i++) begin
      read_head(h);
      e = mq.pop_front();
      checks++;
      if (h !== e) begin
        errors++;
        $display("FAIL basic_pop%0d: got %h expected %h", i, h, e);
      end
    end
    checks++;
    if (data_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_empty: got ready %b expected 0", data_ready);
    end
  endtask

  task automatic test_parity();
    logic [10:0] h, e;
    send_frame(8'h55, 8'h1A, 1'b1, 1'b1, 8'h00, 1'b0);
    checks++;
    if (head_pe !== 1'b1 || rbr_dout !== 8'h55 || err_in_fifo !== 1'b1) begin
      errors++;
      $display("FAIL parity_head: got pe %b data %h err %b expected 1 55 1", head_pe, rbr_dout, err_in_fifo);
    end
    read_head(h);
    e = mq.pop_front();
    checks++;
    if (h !== e || err_in_fifo !== 1'b0) begin
      errors++;
      $display("FAIL parity_pop: got %h err %b expected %h 0", h, err_in_fifo, e);
    end
  endtask

  task automatic test_glitch();
    logic [10:0] h, e;
    wait_tick();
    hold_line(1'b0, 5);
    hold_line(1'b1, 40);
    checks++;
    if (fifo_count !== '0) begin
      errors++;
      $display("FAIL glitch_nopush: got %0d expected 0", fifo_count);
    end
    send_frame(8'h81, 8'h03, 1'b0, 1'b1, 8'h00, 1'b0);
    read_head(h);
    e = mq.pop_front();
    checks++;
    if (h !== e) begin
      errors++;
      $display("FAIL glitch_next: got %h expected %h", h, e);
    end
  endtask

  task automatic test_break();
    logic [10:0] h, e;
    lcr = 8'h03;
    wait_tick();
    hold_line(1'b0, 20 * OS);
    model_push(11'h600);
    checks++;
    if (fifo_count !== CW'(mq.size()) || err_in_fifo !== 1'b1) begin
      errors++;
      $display("FAIL break_push: got count %0d err %b expected %0d 1", fifo_count, err_in_fifo, mq.size());
    end
    hold_line(1'b0, 6 * OS);
    checks++;
    if (fifo_count !== CW'(mq.size())) begin
      errors++;
      $display("FAIL break_hold: got %0d expected %0d", fifo_count, mq.size());
    end
    hold_line(1'b1, 20);
    send_frame(8'h5A, 8'h03, 1'b0, 1'b1, 8'h00, 1'b0);
    while (mq.size() > 0) begin
      read_head(h);
      e = mq.pop_front();
      checks++;
      if (h !== e) begin
        errors++;
        $display("FAIL break_pop: got %h expected %h", h, e);
      end
    end
  endtask

  task automatic test_overrun();
    logic [10:0] h, e;
    for (int i = 0; i < DEPTH + 1; i++) send_frame(8'($urandom), 8'h03, 1'b0, 1'b1, 8'h00, 1'b0);
    checks++;
    if (fifo_count !== CW'(mq.size()) || overrun_err !== m_ovr) begin
      errors++;
      $display("FAIL overrun_set: got count %0d ovr %b expected %0d %b", fifo_count, overrun_err, mq.size(), m_ovr);
    end
    lsr_rd = 1'b1;
    @(posedge clk);
    #2;
    lsr_rd = 1'b0;
    m_ovr = 1'b0;
    checks++;
    if (overrun_err !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: got %b expected 0", overrun_err);
    end
    while (mq.size() > 0) begin
      read_head(h);
      e = mq.pop_front();
      checks++;
      if (h !== e) begin
        errors++;
        $display("FAIL overrun_data: got %h expected %h", h, e);
      end
    end
    for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 8'h03, 1'b0, 1'b1, 8'h00, 1'b0);
    send_frame(8'($urandom), 8'h03, 1'b0, 1'b1, 8'h00, 1'b1);
    checks++;
    if (fifo_count !== CW'(mq.size()) || overrun_err !== m_ovr) begin
      errors++;
      $display("FAIL overrun_poppush: got count %0d ovr %b expected %0d %b", fifo_count, overrun_err, mq.size(), m_ovr);
    end
    while (mq.size() > 0) begin
      read_head(h);
      e = mq.pop_front();
      checks++;
      if (h !== e) begin
        errors++;
        $display("FAIL poppush_data: got %h expected %h", h, e);
      end
    end
  endtask

  task automatic test_noise();
    logic [10:0] h, e;
    send_frame(8'hC3, 8'h03, 1'b0, 1'b1, 8'hFF, 1'b0);
    send_frame(8'h96, 8'h0B, 1'b0, 1'b1, 8'h5A, 1'b0);
    for (int i = 0; i < 2; i++) begin
      read_head(h);
      e = mq.pop_front();
      checks++;
      if (h !== e) begin
        errors++;
        $display("FAIL noise_vote%0d: got %h expected %h", i, h, e);
      end
    end
  endtask

  task automatic test_trig();
    trig_level = CW'(4);
    for (int i = 0; i < 3; i++) send_frame(8'($urandom), 8'h03, 1'b0, 1'b1, 8'h00, 1'b0);
    checks++;
    if (rx_trig !== model_trig()) begin
      errors++;
      $display("FAIL trig_below: got %b expected %b", rx_trig, model_trig());
    end
    send_frame(8'h7E, 8'h03, 1'b0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (rx_trig !== model_trig() || err_in_fifo !== model_err()) begin
      errors++;
      $display("FAIL trig_at: got trig %b err %b expected %b %b", rx_trig, err_in_fifo, model_trig(), model_err());
    end
    trig_level = '0;
    #1;
    checks++;
    if (rx_trig !== 1'b0) begin
      errors++;
      $display("FAIL trig_zero: got %b expected 0", rx_trig);
    end
    trig_level = CW'(4);
    fifo_clr = 1'b1;
    @(posedge clk);
    #2;
    fifo_clr = 1'b0;
    mq.delete();
    checks++;
    if (fifo_count !== '0 || rx_trig !== 1'b0 || err_in_fifo !== 1'b0 || data_ready !== 1'b0) begin
      errors++;
      $display("FAIL fifo_clr: got count %0d trig %b err %b ready %b expected 0 0 0 0",
               fifo_count, rx_trig, err_in_fifo, data_ready);
    end
  endtask

  task automatic test_random();
    logic [7:0] cfg, d, nz;
    bit bp, sv;
    logic [10:0] h, e;
    for (int i = 0; i < 12; i++) begin
      cfg = 8'($urandom);
      d = 8'($urandom);
      nz = 8'($urandom) & 8'($urandom);
      bp = cfg[3] && ($urandom_range(0, 3) == 0);
      sv = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 7) == 0) d = 8'h00;
      send_frame(d, cfg, bp, sv, nz, 1'b0);
      checks++;
      if (fifo_count !== CW'(mq.size()) || err_in_fifo !== model_err() || rx_trig !== model_trig()) begin
        errors++;
        $display("FAIL rand_status%0d: got count %0d err %b trig %b expected %0d %b %b",
                 i, fifo_count, err_in_fifo, rx_trig, mq.size(), model_err(), model_trig());
      end
      if ($urandom_range(0, 1) == 1) begin
        read_head(h);
        e = mq.pop_front();
        checks++;
        if (h !== e) begin
          errors++;
          $display("FAIL rand_pop%0d: got %h expected %h", i, h, e);
        end
      end
    end
    while (mq.size() > 0) begin
      read_head(h);
      e = mq.pop_front();
      checks++;
      if (h !== e) begin
        errors++;
        $display("FAIL rand_drain: got %h expected %h", h, e);
      end
    end
  endtask

  initial begin
    srx = 1'b1;
    lcr = 8'h00;
    rd_en = 1'b0;
    lsr_rd = 1'b0;
    fifo_clr = 1'b0;
    trig_level = '0;
    test_reset();
    test_basic_8n1();
    test_parity();
    test_glitch();
    test_break();
    test_overrun();
    test_noise();
    test_trig();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
